// File: rtl/fmap_stream_reader.sv
// Streams the conv1 binary feature map in raster order, one pixel position (all channels)
// per valid/ready beat, framed by a begin_read/done_read pulse handshake.
module fmap_stream_reader #(
   parameter int ROWS     = 12,
   parameter int COLS     = 12,
   parameter int CHANNELS = 18,
   parameter int RW       = $clog2(ROWS),
   parameter int CW       = $clog2(COLS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                begin_read,
   input  logic                in_fmap [0:ROWS*COLS*CHANNELS-1],
   output logic                out_valid,
   input  logic                out_ready,
   output logic [CHANNELS-1:0] out_pixel,
   output logic [RW-1:0]       out_row,
   output logic [CW-1:0]       out_col,
   output logic                out_last,
   output logic                busy,
   output logic                done_read
);

   localparam int NBITS = ROWS * COLS * CHANNELS;
   localparam int IW    = $clog2(NBITS);

   typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

   state_t              state;
   state_t              state_next;
   logic [RW-1:0]       fetch_row;
   logic [CW-1:0]       fetch_col;
   logic                fetch_last;
   logic                load;
   logic                accept_last;
   logic [IW-1:0]       pos_idx;
   logic [CHANNELS-1:0] gather;

   assign fetch_last  = (fetch_row == RW'(ROWS - 1)) && (fetch_col == CW'(COLS - 1));
   assign load        = (state == READ) && (!out_valid || out_ready);
   assign accept_last = (state == DRAIN) && out_valid && out_ready;
   assign busy        = (state != IDLE);

   // Index math at full map width so c*ROWS*COLS never truncates.
   always_comb begin
      pos_idx = IW'(fetch_row) * IW'(COLS) + IW'(fetch_col);
      gather  = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         gather[c] = in_fmap[IW'(c * ROWS * COLS) + pos_idx];
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (begin_read) state_next = READ;
         READ:    if (load && fetch_last) state_next = DRAIN;
         DRAIN:   if (accept_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_row <= '0;
         fetch_col <= '0;
      end else if (state == IDLE && begin_read) begin
         fetch_row <= '0;
         fetch_col <= '0;
      end else if (load) begin
         if (fetch_col == CW'(COLS - 1)) begin
            fetch_col <= '0;
            fetch_row <= fetch_last ? '0 : fetch_row + 1'b1;
         end else begin
            fetch_col <= fetch_col + 1'b1;
         end
      end
   end

   // Data registers keep their last values after the final beat; only valid/last drop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_pixel <= '0;
         out_row   <= '0;
         out_col   <= '0;
         out_last  <= 1'b0;
         done_read <= 1'b0;
      end else begin
         done_read <= accept_last;
         if (load) begin
            out_valid <= 1'b1;
            out_pixel <= gather;
            out_row   <= fetch_row;
            out_col   <= fetch_col;
            out_last  <= fetch_last;
         end else if (accept_last) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fmap_stream_reader.sv
// Directed-plus-random bench for fmap_stream_reader; beats are predicted from the map
// contents and raster order, independent of the reader's internal structure.
module tb_fmap_stream_reader;

   localparam int ROWS     = 12;
   localparam int COLS     = 12;
   localparam int CHANNELS = 18;
   localparam int RW       = 4;
   localparam int CW       = 4;
   localparam int BEATS    = ROWS * COLS;
   localparam int NBITS    = ROWS * COLS * CHANNELS;

   logic                clk = 1'b0;
   logic                rst;
   logic                begin_read;
   logic                fmap [0:NBITS-1];
   logic                out_valid;
   logic                out_ready;
   logic [CHANNELS-1:0] out_pixel;
   logic [RW-1:0]       out_row;
   logic [CW-1:0]       out_col;
   logic                out_last;
   logic                busy;
   logic                done_read;

   int total = 0;
   int bad   = 0;

   fmap_stream_reader #(
      .ROWS(ROWS), .COLS(COLS), .CHANNELS(CHANNELS), .RW(RW), .CW(CW)
   ) dut (
      .clk(clk), .rst(rst), .begin_read(begin_read), .in_fmap(fmap),
      .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
      .out_row(out_row), .out_col(out_col), .out_last(out_last),
      .busy(busy), .done_read(done_read)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected {valid,busy,done,last,row,col,pixel} while beat n is presented.
   function automatic logic [29:0] exp_beat(input int n);
      int r = n / COLS;
      int k = n % COLS;
      logic [CHANNELS-1:0] pix;
      for (int c = 0; c < CHANNELS; c++) pix[c] = fmap[c * BEATS + r * COLS + k];
      return {1'b1, 1'b1, 1'b0, (n == BEATS - 1), 4'(r), 4'(k), pix};
   endfunction

   // Caller has begin_read=1 ahead of the sampling edge. abort_beat returns early while
   // that beat is presented; chain leaves begin_read=1 on the done_read cycle.
   task automatic run_frame(input int pct, input int restart_beat, input int abort_beat,
                            input bit chain);
      int n   = 0;
      int cyc = 0;
      @(negedge clk);
      begin_read = 1'b0;
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_valid_low", {31'd0, out_valid}, 32'd0);
      while (n < BEATS) begin
         @(negedge clk);
         cyc++;
         if (cyc > 6 * BEATS) begin
            check("timeout", n, BEATS);
            break;
         end
         if (n == abort_beat) begin
            begin_read = 1'b0;
            return;
         end
         check($sformatf("beat%0d", n),
               {2'b0, out_valid, busy, done_read, out_last, out_row, out_col, out_pixel},
               {2'b0, exp_beat(n)});
         begin_read = (n == restart_beat);
         out_ready  = ($urandom_range(99) < pct);
         if (out_ready) n++;
      end
      @(negedge clk);
      begin_read = 1'b0;
      check("done_flags", {28'd0, out_valid, busy, done_read, out_last}, 32'b0010);
      if (chain) begin
         begin_read = 1'b1;
      end else begin
         @(negedge clk);
         check("done_single", {31'd0, done_read}, 32'd0);
      end
   endtask

   task automatic start_frame();
      @(negedge clk);
      begin_read = 1'b1;
   endtask

   initial begin
      rst        = 1'b1;
      begin_read = 1'b0;
      out_ready  = 1'b0;
      for (int i = 0; i < NBITS; i++) fmap[i] = 1'b0;
      #1;
      check("reset_outputs",
            {2'b0, out_valid, busy, done_read, out_last, out_row, out_col, out_pixel}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Checkerboard fill, no stall, then with 50% backpressure.
      for (int c = 0; c < CHANNELS; c++)
         for (int r = 0; r < ROWS; r++)
            for (int k = 0; k < COLS; k++)
               fmap[c * BEATS + r * COLS + k] = 1'((r + k + c) % 2);
      start_frame();
      run_frame(100, -1, -1, 1'b0);
      start_frame();
      run_frame(50, -1, -1, 1'b0);

      // Single hot bit: channel 17 at (5,7).
      for (int i = 0; i < NBITS; i++) fmap[i] = 1'b0;
      fmap[17 * BEATS + 5 * COLS + 7] = 1'b1;
      start_frame();
      run_frame(100, -1, -1, 1'b0);

      // Random map with an ignored restart pulse at beat 40.
      for (int i = 0; i < NBITS; i++) fmap[i] = 1'($urandom_range(1));
      start_frame();
      run_frame(50, 40, -1, 1'b0);

      // Asynchronous reset mid-frame, then a full frame from (0,0).
      start_frame();
      run_frame(100, -1, 70, 1'b0);
      #2 rst = 1'b1;
      #1;
      check("midframe_reset",
            {2'b0, out_valid, busy, done_read, out_last, out_row, out_col, out_pixel}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      start_frame();
      run_frame(70, -1, -1, 1'b0);

      // Back-to-back frames: second begin_read on the done_read cycle.
      for (int i = 0; i < NBITS; i++) fmap[i] = 1'($urandom_range(1));
      start_frame();
      run_frame(100, -1, -1, 1'b1);
      run_frame(100, -1, -1, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fmap_stream_reader.md
Name: fmap_stream_reader

Overview:
- Reader side of the conv1 output feature-map buffer.
- After conv1 completes, it walks the binary ROWS x COLS x CHANNELS map in raster order and emits one pixel position per beat on a valid/ready stream.
- Each beat carries all CHANNELS bits for that position; conv2 and other downstream consumers take this stream.
- Uses the same start/done pulse handshake as the conv engines.

Parameters:
ROWS, 12, feature-map height
COLS, 12, feature-map width
CHANNELS, 18, feature maps per frame; one bit per channel per beat
RW, $clog2(ROWS), row counter width (derived)
CW, $clog2(COLS), column counter width (derived)

Ports:
clk  input  1  single clock; all state updates on posedge
rst  input  1  asynchronous, active-high reset
begin_read  input  1  start pulse; sampled only in IDLE
in_fmap  input  unpacked [0:ROWS*COLS*CHANNELS-1] of 1 bit  source map; element (c,r,k) at index c*ROWS*COLS + r*COLS + k; must be held stable while busy=1
out_valid  output  1  beat present on out_* data
out_ready  input  1  consumer accepts beat when out_valid & out_ready at posedge
out_pixel  output  CHANNELS  bit c = in_fmap[c*ROWS*COLS + out_row*COLS + out_col]
out_row  output  RW  row of current beat
out_col  output  CW  column of current beat
out_last  output  1  high with the beat at (ROWS-1, COLS-1) only
busy  output  1  high in READ or DRAIN
done_read  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE. out_valid, out_pixel, out_row, out_col, out_last, busy, done_read all 0. Internal fetch counters also 0.
- States: IDLE, READ (fetch counters not yet past last position), DRAIN (last beat loaded, awaiting acceptance).
- IDLE -> READ on a posedge with begin_read=1. Fetch counters are (0,0) and busy=1 from the next cycle.
- begin_read while busy=1 is ignored; no restart and no counter disturbance.
- Output register load condition: load = (state==READ) & (~out_valid | out_ready).
  - On load: out_pixel/out_row/out_col are taken from the fetch counters, out_valid<=1, and out_last<=(fetch position is the last one).
  - Fetch counters then advance: column increments; at COLS-1 the column wraps to 0 and the row increments.
  - Loading position (ROWS-1, COLS-1) moves the state to DRAIN.
- Latency: begin_read at edge E0; first beat valid after E1. With out_ready held at 1, one beat per cycle and ROWS*COLS consecutive valid cycles.
- Backpressure: while out_valid=1 and out_ready=0, all out_* outputs hold and the fetch counters do not advance. No beat is dropped or duplicated.
- out_valid is never deasserted in READ without acceptance. The stream is gapless except under backpressure.
- DRAIN, when the last beat is accepted:
  - out_valid<=0, out_last<=0, busy<=0, done_read<=1 for exactly one cycle; state -> IDLE.
  - out_pixel/out_row/out_col keep their last values; they are don't-care while out_valid=0.
- begin_read asserted in the same cycle done_read is high: the state is already IDLE, so it is accepted and a new frame starts. Back-to-back frames are legal.
- out_ready while out_valid=0 has no effect.
- Channel gather is a combinational mux indexed by the fetch counters, followed by the output register. There is no multi-cycle memory latency.
- Counter widths are RW/CW. Index arithmetic is done at a width of at least $clog2(ROWS*COLS*CHANNELS) to avoid truncation.

Test Plan:
- Fill pattern, no stall: in_fmap bit (c,r,k)=(r+k+c)%2; begin_read pulse; out_ready=1 -> 144 beats on consecutive cycles starting 1 cycle after begin_read sampled.
  - Beat n has row=n/12, col=n%12, out_pixel=18'h2AAAA when (r+k) even and 18'h15555 when odd.
  - out_last only on beat 143; done_read pulses the cycle after beat 143; busy=0 then.
- Backpressure: out_ready pseudo-random 50% -> same 144 beats in the same order; out_* stable whenever valid & ~ready; done_read once.
- Single hot bit: only in_fmap[17*144 + 5*12 + 7]=1 -> only beat 67 (row 5, col 7) has out_pixel=18'h20000; all others 0.
- Ignored restart: begin_read re-pulsed at beat 40 -> no effect; sequence continues 41..143; one done_read.
- Reset mid-frame: assert rst asynchronously at beat 70 -> all outputs 0 immediately. Then begin_read -> full frame restarts from (0,0).
- Back-to-back: begin_read asserted on the done_read cycle -> second frame's beat 0 valid the next cycle; 288 total beats, 2 done_read pulses.
